// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select port of the shared 8:1 result mux.
// One owner at a time, one dead cycle between owners, bounded hold under contention.
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [3:0] sel,
  output logic       valid,
  output logic       preempt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // With timeout disabled the counter simply saturates at its full range.
  localparam logic [7:0] HOLD_LAST  = (MAX_HOLD == 0) ? 8'hFF : 8'(MAX_HOLD - 1);
  localparam bit         TIMEOUT_EN = (MAX_HOLD != 0);

  state_t      state;
  logic [2:0]  ptr;
  logic [2:0]  owner;
  logic [7:0]  hold_cnt;

  logic [15:0] req_dbl;
  logic [7:0]  req_rot;
  logic [2:0]  offset;
  logic [2:0]  winner;
  logic        any_req;
  logic        own_req;
  logic        others_req;
  logic        timeout;

  // Rotate requests so bit 0 is the current search start, then take the lowest set bit.
  // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[7:0];
    offset  = '0;
    for (int k = 7; k >= 0; k--) begin
      if (req_rot[k]) offset = 3'(k);
    end
    winner     = ptr + offset;
    any_req    = |req;
    own_req    = req[owner];
    others_req = |(req & ~(8'b1 << owner));
    timeout    = TIMEOUT_EN && (hold_cnt == HOLD_LAST) && own_req && others_req;
  end

  // NOTE: all state and outputs use non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      sel      <= '0;
      valid    <= 1'b0;
      preempt  <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (any_req) begin
            state    <= GRANT;
            owner    <= winner;
            gnt      <= 8'b1 << winner;
            sel      <= {1'b0, winner};
            valid    <= 1'b1;
            hold_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          // A release in the same cycle as a timeout counts as a plain release.
          if (!own_req || timeout) begin
            state   <= GAP;
            gnt     <= '0;
            valid   <= 1'b0;
            ptr     <= owner + 3'd1;
            preempt <= own_req;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed and random checks for mux_rr_arbiter: one instance with MAX_HOLD=4, one with MAX_HOLD=2.
module tb_mux_rr_arbiter;

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    logic [3:0] sel;
    logic       valid;
    logic       preempt;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_a, req_b;
  logic [7:0] gnt_a, gnt_b;
  logic [3:0] sel_a, sel_b;
  logic       valid_a, valid_b;
  logic       preempt_a, preempt_b;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[$];

  mux_rr_arbiter #(.MAX_HOLD(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a),
    .gnt(gnt_a), .sel(sel_a), .valid(valid_a), .preempt(preempt_a)
  );

  mux_rr_arbiter #(.MAX_HOLD(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b),
    .gnt(gnt_b), .sel(sel_b), .valid(valid_b), .preempt(preempt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] r, input logic [7:0] g, input logic [3:0] s,
                     input logic v, input logic p);
    vec_t e;
    e.req = r; e.gnt = g; e.sel = s; e.valid = v; e.preempt = p;
    vecs.push_back(e);
  endtask

  task automatic step_a(input logic [7:0] r);
    req_a = r;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic [7:0] r);
    req_b = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_b(input string name, input logic [7:0] g, input logic [3:0] s,
                         input logic p);
    check({name, "_gnt"}, 32'(gnt_b), 32'(g));
    check({name, "_sel"}, 32'(sel_b), 32'(s));
    check({name, "_valid"}, 32'(valid_b), 32'(g != 8'h00));
    check({name, "_preempt"}, 32'(preempt_b), 32'(p));
  endtask

  initial begin
    logic [7:0] prev_gnt;
    logic [3:0] prev_sel;

    // Round robin: each owner drops its request for one cycle right after its grant.
    for (int k = 0; k < 8; k++) begin
      add(8'hFF, 8'(1 << k), 4'(k), 1'b1, 1'b0);
      add(8'hFF & ~8'(1 << k), 8'h00, 4'(k), 1'b0, 1'b0);
    end
    add(8'hFF, 8'h01, 4'd0, 1'b1, 1'b0);
    add(8'hFE, 8'h00, 4'd0, 1'b0, 1'b0);
    // Wraparound: owner 6 releases so ptr=7, then 0 wins over 6.
    add(8'h40, 8'h40, 4'd6, 1'b1, 1'b0);
    add(8'h00, 8'h00, 4'd6, 1'b0, 1'b0);
    add(8'h41, 8'h01, 4'd0, 1'b1, 1'b0);
    add(8'h40, 8'h00, 4'd0, 1'b0, 1'b0);
    add(8'h40, 8'h40, 4'd6, 1'b1, 1'b0);
    add(8'h00, 8'h00, 4'd6, 1'b0, 1'b0);
    add(8'h00, 8'h00, 4'd6, 1'b0, 1'b0);
    // Simultaneous requests from IDLE with ptr=7: 3 is first in scan order.
    add(8'h28, 8'h08, 4'd3, 1'b1, 1'b0);
    add(8'h20, 8'h00, 4'd3, 1'b0, 1'b0);
    add(8'h00, 8'h00, 4'd3, 1'b0, 1'b0);
    // Timeout with MAX_HOLD=4: four grant cycles, then GAP with preempt, then 5.
    add(8'h04, 8'h04, 4'd2, 1'b1, 1'b0);
    add(8'h24, 8'h04, 4'd2, 1'b1, 1'b0);
    add(8'h24, 8'h04, 4'd2, 1'b1, 1'b0);
    add(8'h24, 8'h04, 4'd2, 1'b1, 1'b0);
    add(8'h24, 8'h00, 4'd2, 1'b0, 1'b1);
    add(8'h24, 8'h20, 4'd5, 1'b1, 1'b0);
    add(8'h04, 8'h00, 4'd5, 1'b0, 1'b0);
    // Release on the timeout edge is a plain release: no preempt.
    add(8'h04, 8'h04, 4'd2, 1'b1, 1'b0);
    add(8'h24, 8'h04, 4'd2, 1'b1, 1'b0);
    add(8'h24, 8'h04, 4'd2, 1'b1, 1'b0);
    add(8'h24, 8'h04, 4'd2, 1'b1, 1'b0);
    add(8'h20, 8'h00, 4'd2, 1'b0, 1'b0);
    add(8'h20, 8'h20, 4'd5, 1'b1, 1'b0);
    add(8'h00, 8'h00, 4'd5, 1'b0, 1'b0);
    add(8'h00, 8'h00, 4'd5, 1'b0, 1'b0);

    rst_n = 1'b0;
    req_a = 8'h00;
    req_b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt_a", 32'(gnt_a), 32'h0);
    check("rst_sel_a", 32'(sel_a), 32'h0);
    check("rst_valid_a", 32'(valid_a), 32'h0);
    check("rst_preempt_a", 32'(preempt_a), 32'h0);
    check_b("rst_b", 8'h00, 4'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      step_a(vecs[i].req);
      check($sformatf("vec%0d_gnt", i), 32'(gnt_a), 32'(vecs[i].gnt));
      check($sformatf("vec%0d_sel", i), 32'(sel_a), 32'(vecs[i].sel));
      check($sformatf("vec%0d_valid", i), 32'(valid_a), 32'(vecs[i].valid));
      check($sformatf("vec%0d_preempt", i), 32'(preempt_a), 32'(vecs[i].preempt));
    end

    // Reset asserted between edges while 4 owns the mux clears outputs at once.
    step_a(8'h10);
    check("pre_rst_gnt", 32'(gnt_a), 32'h10);
    check("pre_rst_sel", 32'(sel_a), 32'h4);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt", 32'(gnt_a), 32'h0);
    check("async_rst_valid", 32'(valid_a), 32'h0);
    check("async_rst_sel", 32'(sel_a), 32'h0);
    req_a = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_a(8'h00);
      check($sformatf("post_rst_idle%0d_gnt", i), 32'(gnt_a), 32'h0);
      check($sformatf("post_rst_idle%0d_valid", i), 32'(valid_a), 32'h0);
    end
    step_a(8'hFF);
    check("post_rst_ptr0_gnt", 32'(gnt_a), 32'h01);
    step_a(8'h00);
    step_a(8'h00);

    // Uncontended owner keeps the mux well past MAX_HOLD.
    step_a(8'h04);
    check("solo_gnt", 32'(gnt_a), 32'h04);
    for (int i = 0; i < 25; i++) begin
      step_a(8'h04);
      check($sformatf("solo%0d_gnt", i), 32'(gnt_a), 32'h04);
      check($sformatf("solo%0d_preempt", i), 32'(preempt_a), 32'h0);
    end
    step_a(8'h00);
    step_a(8'h00);

    // Lone preempted requester, MAX_HOLD=2: regranted when the rival has gone by GAP.
    step_b(8'h08); check_b("lone_g0", 8'h08, 4'd3, 1'b0);
    step_b(8'h08); check_b("lone_g1", 8'h08, 4'd3, 1'b0);
    step_b(8'h18); check_b("lone_gap", 8'h00, 4'd3, 1'b1);
    step_b(8'h08); check_b("lone_regrant", 8'h08, 4'd3, 1'b0);
    step_b(8'h08); check_b("lone_hold", 8'h08, 4'd3, 1'b0);
    step_b(8'h18); check_b("rival_gap", 8'h00, 4'd3, 1'b1);
    step_b(8'h18); check_b("rival_win", 8'h10, 4'd4, 1'b0);
    step_b(8'h00); check_b("rival_rel", 8'h00, 4'd4, 1'b0);

    // Random requests: structural invariants every cycle.
    prev_gnt = gnt_a;
    prev_sel = sel_a;
    for (int i = 0; i < 10000; i++) begin
      step_a(8'($urandom_range(0, 255)));
      check("inv_onehot", 32'($countones(gnt_a) <= 1), 32'h1);
      check("inv_valid", 32'(valid_a), 32'(|gnt_a));
      check("inv_sel3", 32'(sel_a[3]), 32'h0);
      if (prev_gnt == 8'h00 && gnt_a == 8'h00)
        check("inv_sel_stable", 32'(sel_a), 32'(prev_sel));
      if (prev_gnt != 8'h00 && gnt_a != 8'h00)
        check("inv_no_direct_handover", 32'(gnt_a), 32'(prev_gnt));
      prev_gnt = gnt_a;
      prev_sel = sel_a;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
